// File: rtl/eth_hdr_seq_if.sv
// Handshake and header-buffer bus between the header sequencer, its three
// field writers and the buffer write port.
`timescale 1ns/1ps
interface eth_hdr_seq_if #(
   parameter int ADDR_W = 6,
   parameter int IDX_W  = 5
);
   logic                 i_start;
   logic [2:0]           i_skip;
   logic [2:0]           o_trig;
   logic [2:0]           i_wr_ready;
   logic [3*IDX_W-1:0]   i_wr_idx;
   logic [23:0]          i_wr_byte;
   logic [2:0]           i_wr_en;
   logic [ADDR_W-1:0]    o_buf_addr;
   logic [7:0]           o_buf_data;
   logic                 o_buf_we;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_err;

   modport master (
      output i_start, i_skip, i_wr_ready, i_wr_idx, i_wr_byte, i_wr_en,
      input  o_trig, o_buf_addr, o_buf_data, o_buf_we, o_busy, o_done, o_err
   );

   modport slave (
      input  i_start, i_skip, i_wr_ready, i_wr_idx, i_wr_byte, i_wr_en,
      output o_trig, o_buf_addr, o_buf_data, o_buf_we, o_busy, o_done, o_err
   );
endinterface

// File: rtl/eth_hdr_seq.sv
// Header build sequencer: runs the Ethernet, IP and UDP field writers in turn
// and muxes the selected writer's byte writes onto the header buffer port.
`timescale 1ns/1ps
module eth_hdr_seq #(
   parameter int ADDR_W  = 6,
   parameter int IDX_W   = 5,
   parameter int BASE0   = 0,
   parameter int BASE1   = 14,
   parameter int BASE2   = 34,
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 200
) (
   input logic          i_clk,
   input logic          i_rst,
   eth_hdr_seq_if.slave bus
);

   typedef enum logic [4:0] {
      ST_IDLE = 5'b00001,
      ST_RUN  = 5'b00010,
      ST_GAP  = 5'b00100,
      ST_DONE = 5'b01000,
      ST_ERR  = 5'b10000
   } state_t;

   // Lowest non-skipped writer index >= lo; bit 2 flags that one exists.
   function automatic logic [2:0] pick_next(input logic [2:0] skip, input logic [2:0] lo);
      logic [2:0] r;
      r = 3'b000;
      for (int j = 2; j >= 0; j--) begin
         if (!skip[j] && (3'(j) >= lo)) begin
            r = {1'b1, 2'(j)};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        k_q, k_d;
   logic [2:0]        skip_q, skip_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [2:0]        trig_q, trig_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              start_q, start_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [7:0]        buf_data_q, buf_data_d;
   logic              buf_we_q, buf_we_d;

   logic              start_edge_s;
   logic [TO_W-1:0]   cnt_inc_s;
   logic [2:0]        nxt_s;
   logic [ADDR_W-1:0] base_s;
   logic [IDX_W-1:0]  idx_s;
   logic [7:0]        byte_s;
   logic              en_s;
   logic              wr_active_s;

   assign start_edge_s = bus.i_start & ~start_q;
   assign cnt_inc_s    = cnt_q + TO_W'(1);

   // Sequencer next-state and registered control outputs.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      skip_d  = skip_q;
      cnt_d   = cnt_q;
      trig_d  = trig_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      start_d = bus.i_start;
      nxt_s   = 3'b000;
      case (state_q)
         ST_IDLE: begin
            if (start_edge_s) begin
               skip_d = bus.i_skip;
               err_d  = 1'b0;
               busy_d = 1'b1;
               k_d    = 2'd0;
               nxt_s  = pick_next(bus.i_skip, 3'd0);
               if (nxt_s[2]) begin
                  k_d     = nxt_s[1:0];
                  trig_d  = 3'b001 << nxt_s[1:0];
                  cnt_d   = {TO_W{1'b0}};
                  state_d = ST_RUN;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.i_wr_ready[k_q]) begin
               trig_d  = 3'b000;
               state_d = ST_GAP;
            end else if (cnt_inc_s == TO_W'(TIMEOUT)) begin
               trig_d  = 3'b000;
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_GAP: begin
            nxt_s = pick_next(skip_q, {1'b0, k_q} + 3'd1);
            if (nxt_s[2]) begin
               k_d     = nxt_s[1:0];
               trig_d  = 3'b001 << nxt_s[1:0];
               cnt_d   = {TO_W{1'b0}};
               state_d = ST_RUN;
            end else begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            trig_d  = 3'b000;
            state_d = ST_IDLE;
         end
         default: begin
            trig_d  = 3'b000;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Select the current writer's byte lane and form the buffer write.
   always_comb begin
      base_s = {ADDR_W{1'b0}};
      idx_s  = {IDX_W{1'b0}};
      byte_s = 8'h00;
      en_s   = 1'b0;
      case (k_q)
         2'd0: begin
            base_s = ADDR_W'(BASE0);
            idx_s  = bus.i_wr_idx[0*IDX_W +: IDX_W];
            byte_s = bus.i_wr_byte[7:0];
            en_s   = bus.i_wr_en[0];
         end
         2'd1: begin
            base_s = ADDR_W'(BASE1);
            idx_s  = bus.i_wr_idx[1*IDX_W +: IDX_W];
            byte_s = bus.i_wr_byte[15:8];
            en_s   = bus.i_wr_en[1];
         end
         2'd2: begin
            base_s = ADDR_W'(BASE2);
            idx_s  = bus.i_wr_idx[2*IDX_W +: IDX_W];
            byte_s = bus.i_wr_byte[23:16];
            en_s   = bus.i_wr_en[2];
         end
         default: begin
            en_s = 1'b0;
         end
      endcase
      wr_active_s = (state_q == ST_RUN) || (state_q == ST_GAP) || (state_q == ST_DONE);
      buf_we_d    = wr_active_s & en_s;
      buf_addr_d  = base_s + ADDR_W'(idx_s);
      buf_data_d  = byte_s;
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         k_q        <= 2'd0;
         skip_q     <= 3'b000;
         cnt_q      <= {TO_W{1'b0}};
         trig_q     <= 3'b000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         buf_addr_q <= {ADDR_W{1'b0}};
         buf_data_q <= 8'h00;
         buf_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         skip_q     <= skip_d;
         cnt_q      <= cnt_d;
         trig_q     <= trig_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         start_q    <= start_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         buf_we_q   <= buf_we_d;
      end
   end

   assign bus.o_trig     = trig_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_done     = done_q;
   assign bus.o_err      = err_q;
   assign bus.o_buf_addr = buf_addr_q;
   assign bus.o_buf_data = buf_data_q;
   assign bus.o_buf_we   = buf_we_q;

endmodule
